// File: rtl/alu_pkg.sv
// Shared widths, ALU select codes and sequencer state encoding.
package alu_pkg;
    localparam int unsigned DW   = 16;
    localparam int unsigned NREG = 8;
    localparam int unsigned RW   = $clog2(NREG);

    localparam logic [3:0] SEL_PASS_A = 4'b0000;
    localparam logic [3:0] SEL_ADD    = 4'b1001;
    localparam logic [3:0] SEL_DBL    = 4'b1100;
    localparam logic [3:0] SEL_INC    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } seq_state_e;
endpackage

// File: rtl/alu_regfile.sv
// NREG x DW register file: two combinational read ports, one synchronous write port.
module alu_regfile #(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 8,
    parameter int unsigned RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr_a,
    input  logic [RW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);
    logic [DW-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues register-file operands to an external combinational ALU, captures its
// result, optionally writes it back and returns a response.
module alu_cmd_sequencer #(
    parameter int unsigned DW   = alu_pkg::DW,
    parameter int unsigned NREG = alu_pkg::NREG,
    parameter int unsigned RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_load,
    input  logic [3:0]    cmd_sel,
    input  logic [RW-1:0] cmd_ra,
    input  logic [RW-1:0] cmd_rb,
    input  logic [RW-1:0] cmd_rd,
    input  logic          cmd_we,
    input  logic [DW-1:0] cmd_imm,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_cout,
    output logic          rsp_eq,
    output logic [DW-1:0] alu_in_a,
    output logic [DW-1:0] alu_in_b,
    output logic          alu_cin,
    output logic [3:0]    alu_sel,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_cout,
    input  logic          alu_cmp
);
    import alu_pkg::*;

    seq_state_e    state;
    logic [RW-1:0] rd_q;
    logic          we_q;
    logic          carry;
    logic          accept;
    logic          rf_we;
    logic [RW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;

    assign accept   = (state == IDLE) && cmd_ready && cmd_valid;
    assign rf_we    = (accept && cmd_load) || ((state == CAPTURE) && we_q);
    assign rf_waddr = (state == CAPTURE) ? rd_q : cmd_rd;
    assign rf_wdata = (state == CAPTURE) ? alu_out : cmd_imm;

    alu_regfile #(.DW(DW), .NREG(NREG), .RW(RW)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (cmd_ra),
        .raddr_b (cmd_rb),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    // Commands are fully serialized, so the register file never needs a bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_cout  <= 1'b0;
            rsp_eq    <= 1'b0;
            alu_in_a  <= '0;
            alu_in_b  <= '0;
            alu_sel   <= '0;
            alu_cin   <= 1'b0;
            carry     <= 1'b0;
            rd_q      <= '0;
            we_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        rd_q      <= cmd_rd;
                        we_q      <= cmd_we;
                        if (cmd_load) begin
                            rsp_data  <= cmd_imm;
                            rsp_cout  <= 1'b0;
                            rsp_eq    <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_in_a <= rdata_a;
                            alu_in_b <= rdata_b;
                            alu_sel  <= cmd_sel;
                            alu_cin  <= carry;
                            state    <= ISSUE;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_data  <= alu_out;
                    rsp_cout  <= alu_cout;
                    rsp_eq    <= alu_cmp;
                    carry     <= alu_cout;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU beside it.
module tb_alu_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_load, cmd_we;
    logic [3:0]  cmd_sel;
    logic [2:0]  cmd_ra, cmd_rb, cmd_rd;
    logic [15:0] cmd_imm;
    logic        rsp_valid, rsp_ready, rsp_cout, rsp_eq;
    logic [15:0] rsp_data;
    logic [15:0] alu_in_a, alu_in_b, alu_out;
    logic        alu_cin, alu_cout, alu_cmp;
    logic [3:0]  alu_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_sel(cmd_sel), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .cmd_we(cmd_we), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_cout(rsp_cout), .rsp_eq(rsp_eq),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_cin(alu_cin),
        .alu_sel(alu_sel), .alu_out(alu_out), .alu_cout(alu_cout), .alu_cmp(alu_cmp)
    );

    // Behavioural arithmetic unit; unknown selects fall back to add-with-carry.
    always_comb begin
        {alu_cout, alu_out} = {1'b0, alu_in_a};
        case (alu_sel)
            4'b0000: {alu_cout, alu_out} = {1'b0, alu_in_a};
            4'b1001: {alu_cout, alu_out} = {1'b0, alu_in_a} + {1'b0, alu_in_b};
            4'b1100: {alu_cout, alu_out} = {1'b0, alu_in_a} + {1'b0, alu_in_a};
            4'b1111: {alu_cout, alu_out} = {1'b0, alu_in_a} + 17'd1;
            default: {alu_cout, alu_out} = {1'b0, alu_in_a} + {1'b0, alu_in_b} + 17'(alu_cin);
        endcase
        alu_cmp = (alu_in_a == alu_in_b);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one command (called at a negedge) and check its response.
    task automatic do_cmd(input string tag, input logic ld, input logic [3:0] sel,
                          input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
                          input logic we, input logic [15:0] imm, input int lat,
                          input logic ecin, input logic [15:0] edata,
                          input logic ecout, input logic eeq, input int stall);
        int n;
        chk({tag, "_ready"}, 16'(cmd_ready), 16'd1);
        cmd_valid = 1'b1; cmd_load = ld; cmd_sel = sel;
        cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_we = we; cmd_imm = imm;
        tick();
        cmd_valid = 1'b0;
        n = 1;
        if (!ld) chk({tag, "_cin"}, 16'(alu_cin), 16'(ecin));
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 16'(n), 16'(lat));
        chk({tag, "_data"}, rsp_data, edata);
        chk({tag, "_cout"}, 16'(rsp_cout), 16'(ecout));
        chk({tag, "_eq"}, 16'(rsp_eq), 16'(eeq));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "_hold_v"}, 16'(rsp_valid), 16'd1);
            chk({tag, "_hold_d"}, rsp_data, edata);
            chk({tag, "_hold_c"}, 16'(rsp_cout), 16'(ecout));
            chk({tag, "_hold_rdy"}, 16'(cmd_ready), 16'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_done_v"}, 16'(rsp_valid), 16'd0);
        chk({tag, "_done_rdy"}, 16'(cmd_ready), 16'd1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_sel = 4'd0;
        cmd_ra = 3'd0; cmd_rb = 3'd0; cmd_rd = 3'd0; cmd_we = 1'b0;
        cmd_imm = 16'd0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 16'(cmd_ready), 16'd0);
        chk("rst_valid", 16'(rsp_valid), 16'd0);
        chk("rst_data", rsp_data, 16'd0);
        chk("rst_ina", alu_in_a, 16'd0);
        chk("rst_sel", 16'(alu_sel), 16'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 16'(cmd_ready), 16'd1);
        chk("post_rst_valid", 16'(rsp_valid), 16'd0);

        do_cmd("pass_r7",  1'b0, 4'b0000, 3'd7, 3'd7, 3'd0, 1'b0, 16'h0000, 3, 1'b0, 16'h0000, 1'b0, 1'b1, 0);
        do_cmd("load_r1",  1'b1, 4'b0000, 3'd0, 3'd0, 3'd1, 1'b0, 16'h1234, 1, 1'b0, 16'h1234, 1'b0, 1'b0, 0);
        do_cmd("pass_r1",  1'b0, 4'b0000, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0000, 3, 1'b0, 16'h1234, 1'b0, 1'b0, 0);
        do_cmd("load_r2",  1'b1, 4'b0000, 3'd0, 3'd0, 3'd2, 1'b0, 16'hFFFF, 1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 0);
        do_cmd("load_r3",  1'b1, 4'b0000, 3'd0, 3'd0, 3'd3, 1'b0, 16'h0001, 1, 1'b0, 16'h0001, 1'b0, 1'b0, 0);
        do_cmd("add_r4",   1'b0, 4'b1001, 3'd2, 3'd3, 3'd4, 1'b1, 16'h0000, 3, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        do_cmd("add_r5",   1'b0, 4'b1001, 3'd3, 3'd3, 3'd5, 1'b1, 16'h0000, 3, 1'b1, 16'h0002, 1'b0, 1'b1, 0);
        do_cmd("pass_r4",  1'b0, 4'b0000, 3'd4, 3'd5, 3'd0, 1'b0, 16'h0000, 3, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
        do_cmd("stall_r5", 1'b0, 4'b0000, 3'd5, 3'd0, 3'd0, 1'b0, 16'h0000, 3, 1'b0, 16'h0002, 1'b0, 1'b0, 5);
        do_cmd("dbl_r2",   1'b0, 4'b1100, 3'd2, 3'd2, 3'd1, 1'b0, 16'h0000, 3, 1'b0, 16'hFFFE, 1'b1, 1'b1, 0);
        do_cmd("pass_r1b", 1'b0, 4'b0000, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0000, 3, 1'b1, 16'h1234, 1'b0, 1'b0, 0);

        // INC with write-back, killed by reset while in ISSUE.
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_sel = 4'b1111;
        cmd_ra = 3'd1; cmd_rb = 3'd0; cmd_rd = 3'd6; cmd_we = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("inc_issue_a", alu_in_a, 16'h1234);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 16'(rsp_valid), 16'd0);
        chk("midrst_ready", 16'(cmd_ready), 16'd0);
        chk("midrst_ina", alu_in_a, 16'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_norsp", 16'(rsp_valid), 16'd0);
            chk("midrst_idle", 16'(cmd_ready), 16'd1);
        end
        do_cmd("pass_r6",  1'b0, 4'b0000, 3'd6, 3'd0, 3'd0, 1'b0, 16'h0000, 3, 1'b0, 16'h0000, 1'b0, 1'b1, 0);
        do_cmd("pass_r1c", 1'b0, 4'b0000, 3'd1, 3'd2, 3'd0, 1'b0, 16'h0000, 3, 1'b0, 16'h0000, 1'b0, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Issue-side counterpart of the combinational 16-bit arithmetic unit. Accepts operation commands over a valid/ready interface and reads operands from an internal 8x16 register file.
- Drives the arithmetic unit's operand, carry-in and select inputs. Captures its result, carry-out and compare outputs.
- Optionally writes the result back, then returns a response over a second valid/ready interface.
- Sits between the level-4 control path and the arithmetic unit; the arithmetic unit is instantiated beside it, not inside it.

Parameters:
- DW, 16, datapath width; must equal the arithmetic unit width.
- NREG, 8, register-file depth; power of two.
- RW, $clog2(NREG), register index width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_load  in  1  1 = write cmd_imm to cmd_rd (no ALU use); 0 = ALU op.
- cmd_sel  in  4  ALU select code.
- cmd_ra  in  RW  operand A register index.
- cmd_rb  in  RW  operand B register index.
- cmd_rd  in  RW  destination register index.
- cmd_we  in  1  write result to cmd_rd (ALU op only).
- cmd_imm  in  DW  load immediate.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DW  result or loaded value.
- rsp_cout  out  1  captured carry-out (0 for load).
- rsp_eq  out  1  captured compare (0 for load).
- alu_in_a  out  DW  to the arithmetic unit in_a.
- alu_in_b  out  DW  to the arithmetic unit in_b.
- alu_cin  out  1  to the arithmetic unit cin; carries the sticky carry flag.
- alu_sel  out  4  to the arithmetic unit sel.
- alu_out  in  DW  from the arithmetic unit ArOut.
- alu_cout  in  1  from the arithmetic unit cout.
- alu_cmp  in  1  from the arithmetic unit compare.

Behaviour:
- Reset (async, rst_n=0) clears the following:
  - all registers to 0;
  - state to IDLE;
  - cmd_ready=0 during reset, 1 in the first cycle after release;
  - rsp_valid=0 and rsp_data/rsp_cout/rsp_eq=0;
  - alu_in_a/alu_in_b/alu_sel/alu_cin=0;
  - carry flag=0.
- Reset mid-operation drops the in-flight command; no register write and no response.
- FSM has four states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, the command is accepted and its fields are latched.
  - Load command: write cmd_imm to reg[cmd_rd] on that edge and set rsp_data=cmd_imm, rsp_cout=0, rsp_eq=0 → RESP.
  - ALU command: alu_in_a<=reg[ra], alu_in_b<=reg[rb], alu_sel<=sel, alu_cin<=carry flag → ISSUE.
- ISSUE: one cycle for the combinational ALU to settle; cmd_ready=0 → CAPTURE.
- CAPTURE:
  - Sample alu_out/alu_cout/alu_cmp into rsp_*.
  - Carry flag <= alu_cout.
  - If we=1, reg[rd] <= alu_out → RESP.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_valid&&rsp_ready.
  - On handshake go to IDLE; cmd_ready rises the following cycle (no same-cycle back-to-back).
- Latency, with accept at edge T:
  - ALU op: rsp_valid high from T+3.
  - Load: rsp_valid high from T+1.
- Register file:
  - Read is combinational from the array in IDLE.
  - Write occurs only in IDLE (load) or CAPTURE (ALU). No bypass is needed, because commands are serialized.
  - ra=rb=rd is legal.
- alu_in_a/b/sel/cin hold their last values outside ISSUE/CAPTURE.
- Width rules:
  - The result is DW bits; carry is separate.
  - Overflow wraps modulo 2^DW with no saturation.
- Out-of-range indices cannot occur, since NREG is a power of two.

Decomposition:
- Package alu_pkg holds:
  - DW;
  - the 4-bit sel localparams, e.g. SEL_PASS_A=4'b0000, SEL_ADD=4'b1001, SEL_DBL=4'b1100, SEL_INC=4'b1111;
  - the FSM state enum seq_state_e.
- One natural sub-module, alu_regfile: NREG x DW, two combinational read ports, one synchronous write port, async reset.

Test Plan:
- Reset → cmd_ready=1 after release, rsp_valid=0, all regs read 0.
- Load r1=0x1234 → rsp_valid at T+1 with rsp_data=0x1234, rsp_cout=0; a later PASS_A on r1 returns 0x1234.
- Load r2=0xFFFF and r3=0x0001, then ADD rd=r4 we=1 → rsp_data=0x0000, rsp_cout=1, rsp_eq=0 at T+3; r4 then reads 0.
- ADD r5=r3+r3 (ra=rb=r3=0x0001) → rsp_data=0x0002, rsp_eq=1; the next ALU op sees alu_cin=0.
- Hold rsp_ready=0 for 5 cycles → rsp_* stable and cmd_ready=0 throughout; after the handshake, cmd_ready=1 one cycle later.
- Assert rst_n=0 during ISSUE of an INC with we=1 → no response, rd unchanged (0), state IDLE.
